// File: rtl/serial_addsub_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// serial_addsub_pkg : state encoding and counter sizing for serial_addsub
// Revision: 1.0
// ============================================================================
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width for a given operand width (never narrower than 1 bit)
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/serial_addsub_full_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// full_adder_1bit : combinational one-bit full-adder cell
// Revision: 1.0
// ============================================================================
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// serial_addsub : bit-serial add/subtract, one bit per clock, LSB first.
// Optional zero flag output enabled by SERIAL_ADDSUB_ZERO_FLAG_EN.
// Revision: 1.0
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    import serial_addsub_pkg::*;

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               w_abit;
    logic               w_bbit;
    logic               w_s;
    logic               w_co;
    logic               w_last;
    logic [WIDTH-1:0]   w_shift_next;

    assign w_abit       = r_a[r_cnt];
    assign w_bbit       = r_b[r_cnt];
    assign w_last       = (r_cnt == c_last);
    assign w_shift_next = {w_s, r_shift[WIDTH-1:1]};

    full_adder_1bit u_fa (
        .a    (w_abit),
        .b    (w_bbit),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_shift <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow on the same adder
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= cin ^ sub;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_carry <= w_co;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        // r_carry is still the carry into the MSB on this edge
                        r_sum  <= w_shift_next;
                        r_cout <= w_co;
                        r_ovf  <= r_carry ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (r_state == SHIFT && w_last) begin
            r_zero <= (w_shift_next == '0);
        end
    end

    assign zero = r_zero;
`endif

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_serial_addsub : scoreboard bench for serial_addsub (WIDTH=4)
// Revision: 1.0
// ============================================================================
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         q[$];
    exp_t         e_mon;
    int           n_vec  = 0;
    int           n_fail = 0;
    logic [W-1:0] last_sum;

    // Reference: integer arithmetic, signed overflow from the true signed result
    function automatic exp_t model(input int av, input int bv, input bit ci, input bit sb);
        exp_t e;
        int m, beff, c, tot, sa, sbv, st;
        m    = 1 << W;
        beff = sb ? (m - 1 - bv) : bv;
        c    = int'(ci ^ sb);
        tot  = av + beff + c;
        sa   = (av   >= m / 2) ? av - m   : av;
        sbv  = (beff >= m / 2) ? beff - m : beff;
        st   = sa + sbv + c;
        e.sum  = W'(tot % m);
        e.cout = (tot >= m);
        e.ovf  = (st > m / 2 - 1) || (st < -(m / 2));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e_mon = q.pop_front();
                chk("sum",      {28'd0, sum},      {28'd0, e_mon.sum});
                chk("cout",     {31'd0, cout},     {31'd0, e_mon.cout});
                chk("overflow", {31'd0, overflow}, {31'd0, e_mon.ovf});
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                chk("zero", {31'd0, zero}, {31'd0, (e_mon.sum == '0)});
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sb);
        exp_t e;
        e = model(int'(av), int'(bv), ci, sb);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
        @(posedge clk);
        q.push_back(e);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("busy_window", {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
            chk("done_pulse",  {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
            chk("sum_hold",    {28'd0, sum},  {28'd0, (k < 4) ? last_sum : e.sum});
        end
        last_sum = e.sum;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_sum",      {28'd0, sum},      32'd0);
        chk("rst_cout",     {31'd0, cout},     32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk("rst_zero", {31'd0, zero}, 32'd0);
`endif
        rst = 1'b0;
        last_sum = '0;

        // Directed arithmetic cases
        run_op(4'b0101, 4'b0101, 1'b0, 1'b0);
        run_op(4'b1111, 4'b0001, 1'b0, 1'b0);
        run_op(4'b0011, 4'b0101, 1'b0, 1'b1);
        run_op(4'b1000, 4'b0001, 1'b0, 1'b1);
        run_op(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Start while busy is ignored; held start gives a 6-cycle period
        e1 = model(1, 1, 1'b0, 1'b0);
        e2 = model(3, 1, 1'b0, 1'b0);
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        q.push_back(e1);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            chk("b2b_busy", {31'd0, busy},
                ((k <= 4) || (k >= 6 && k <= 10)) ? 32'd1 : 32'd0);
            chk("b2b_done", {31'd0, done}, ((k == 4) || (k == 10)) ? 32'd1 : 32'd0);
            chk("b2b_sum",  {28'd0, sum},
                {28'd0, (k < 4) ? last_sum : ((k < 10) ? e1.sum : e2.sum)});
            if (k == 2) begin start = 1'b1; a = 4'b1111; end
            if (k == 3) begin a = 4'b0011; b = 4'b0001; q.push_back(e2); end
            if (k == 6) start = 1'b0;
        end
        last_sum = e2.sum;

        // Reset aborts an operation without a done pulse
        @(negedge clk);
        a = 4'b0110; b = 4'b0011; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",     {31'd0, busy},     32'd0);
        chk("abort_done",     {31'd0, done},     32'd0);
        chk("abort_sum",      {28'd0, sum},      32'd0);
        chk("abort_cout",     {31'd0, cout},     32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        last_sum = '0;
        run_op(4'b0110, 4'b0011, 1'b0, 1'b0);

        // Randomized vectors
        repeat (200) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial add/subtract engine. Processes the same operand format as the 4-bit ripple adder (a, b, carry-in), one bit per clock, LSB first, through a single 1-bit full-adder cell.
- Acts as the area-cheap sequential counterpart to the combinational adder and as the subtract direction of the same datapath.
- Start/done handshake towards a controller. Results are registered and held stable between operations.

Parameters:
- WIDTH, 4, operand and result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, latched on start acceptance
- b  input  WIDTH  operand B, latched on start acceptance
- cin  input  1  carry-in (add) / borrow-in (sub), latched on acceptance
- sub  input  1  0=add, 1=subtract, latched on acceptance
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- cout  output  1  carry-out; in subtract, 1=no borrow
- overflow  output  1  two's-complement overflow

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; operand, shift and counter registers cleared. Reset takes priority over everything and aborts an operation in progress with no done pulse.
- States:
  - IDLE -> SHIFT when start=1. Acceptance edge E0.
  - SHIFT -> DONE after WIDTH bit-edges.
  - DONE -> IDLE unconditionally after one cycle.
- Acceptance at E0 latches:
  - A = a
  - B_eff = b XOR {WIDTH{sub}}
  - carry = cin XOR sub
  - counter = 0
- Arithmetic:
  - sub=0 computes a+b+cin.
  - sub=1 computes a-b-cin (carry-in 1 means borrow).
- Edges E1..E_WIDTH, bit i=counter:
  - s_i = A[i]^B_eff[i]^carry
  - carry <= majority(A[i], B_eff[i], carry)
  - s_i shifted into the internal result shift register
- Overflow is the carry into the MSB XOR the carry out of the MSB. Capture the carry into the MSB at the MSB edge.
- At E_WIDTH: sum, cout and overflow are loaded from the shift register and final carry in one step. The state becomes DONE.
- Latency: done=1 in the cycle after E_WIDTH, i.e. WIDTH cycles after the acceptance edge. busy=1 from E0+ through the DONE cycle.
- sum, cout and overflow never change during SHIFT. They hold the previous result until the next E_WIDTH (or reset).
- start while busy (SHIFT or DONE) is ignored, with no queueing. The inputs a, b, cin, sub may change freely after E0.
- start held high continuously: a new operation is accepted on the first IDLE edge. Back-to-back period = WIDTH+2 cycles.
- No wrap-around beyond WIDTH bits; the carry out of the MSB goes only to cout.

Optional Feature:
- Macro SERIAL_ADDSUB_ZERO_FLAG_EN.
- When defined:
  - Extra output zero (1 bit), registered alongside sum at E_WIDTH.
  - zero=1 iff the new sum==0.
  - Reset value 0; holds between operations.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header serial_addsub_pkg:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - localparam CNT_W = clog2(WIDTH)
- Sub-module full_adder_1bit (a, b, cin -> s, cout), combinational bit cell, instanced once.

Test Plan (WIDTH=4; "+N" = cycles after acceptance edge):
- Add with signed overflow: a=0101, b=0101, cin=0, sub=0 -> at +4 done=1, sum=1010, cout=0, overflow=1. busy=1 for 5 cycles, then 0.
- Add with carry and wrap: a=1111, b=0001, cin=0, sub=0 -> sum=0000, cout=1, overflow=0. zero=1 when the macro is defined.
- Subtract with borrow: a=0011, b=0101, cin=0, sub=1 -> sum=1110, cout=0, overflow=0. Then a=1000, b=0001, sub=1 -> sum=0111, cout=1, overflow=1.
- Busy protocol: start on 0001+0001; pulse start with a=1111 at +2 -> ignored, result sum=0010. Hold start high -> next acceptance exactly 6 cycles after the first. sum stays 0010 throughout the second SHIFT.
- Reset mid-op: start 0110+0011, assert rst at +2 -> next cycle busy=0, sum=0, no done pulse. A fresh start then gives sum=1001 at +4.
- Random: 200 random a/b/cin/sub vectors -> sum/cout/overflow match a golden model of {cout,sum}=a+(b^{4{sub}})+(cin^sub).
